// File: rtl/ram_stream_reader.sv
// Read sequencer for the narrow port of the asymmetric RAM: walks a wrapping
// address range and emits the words as a valid/ready stream with a last flag.
module ram_stream_reader #(
    parameter int WIDTHB     = 4,
    parameter int SIZE       = 4096,
    parameter int ADDRWIDTHB = $clog2(SIZE/WIDTHB),
    parameter int LENWIDTH   = ADDRWIDTHB+1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDRWIDTHB-1:0] base,
    input  logic [LENWIDTH-1:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  enaB,
    output logic [ADDRWIDTHB-1:0] addrB,
    input  logic [WIDTHB-1:0]     doB,
    output logic [WIDTHB-1:0]     m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready
);
    localparam int DEPTH = SIZE/WIDTHB;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDRWIDTHB-1:0] addr_q, addr_d;
    logic [LENWIDTH-1:0]   cnt_q, cnt_d;
    logic                  infl_q, infl_d;
    logic                  infl_last_q, infl_last_d;
    logic [WIDTHB:0]       fifo_q [4];
    logic [WIDTHB:0]       fifo_d [4];
    logic [1:0]            wr_q, wr_d, rd_q, rd_d;
    logic [2:0]            occ_q, occ_d;

    logic [3:0] credit;
    logic       issue, push, pop;

    // Credit counts words already owned by the FIFO plus the one read in flight,
    // so a push can never land on a full FIFO.
    assign credit = 4'(occ_q) + 4'(infl_q);
    assign issue  = (state_q == S_RUN) && (cnt_q != '0) && (credit < 4'd4);
    assign push   = infl_q;
    assign pop    = (occ_q != 3'd0) && m_ready;

    always_comb begin
        fifo_d = fifo_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        if (push) begin
            fifo_d[wr_q] = {infl_last_q, doB};
            wr_d         = wr_q + 2'd1;
        end
        if (pop) rd_d = rd_q + 2'd1;
        occ_d = 3'(occ_q + {2'b0, push} - {2'b0, pop});
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        infl_d      = 1'b0;
        infl_last_d = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                addr_d  = base;
                cnt_d   = len;
                state_d = (len == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (issue) begin
                    addr_d      = (addr_q == ADDRWIDTHB'(DEPTH-1)) ? '0 : addr_q + 1'b1;
                    cnt_d       = cnt_q - 1'b1;
                    infl_d      = 1'b1;
                    infl_last_d = (cnt_q == LENWIDTH'(1));
                end
                if (cnt_d == '0) state_d = S_DRAIN;
            end
            // Looking at the next occupancy lets done follow the final pop directly.
            S_DRAIN: if (occ_d == 3'd0 && !infl_q) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            wr_q        <= 2'd0;
            rd_q        <= 2'd0;
            occ_q       <= 3'd0;
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            occ_q       <= occ_d;
            fifo_q      <= fifo_d;
        end
    end

    assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done    = (state_q == S_DONE);
    assign enaB    = issue;
    assign addrB   = addr_q;
    assign m_valid = (occ_q != 3'd0);
    assign m_data  = m_valid ? fifo_q[rd_q][WIDTHB-1:0] : '0;
    assign m_last  = m_valid & fifo_q[rd_q][WIDTHB];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a behavioral narrow-read RAM
// holding word i = i mod 16.
module tb_ram_stream_reader;
    logic        clk = 1'b0;
    logic        rst, start, busy, done, enaB, m_valid, m_last, m_ready;
    logic [9:0]  base, addrB;
    logic [10:0] len;
    logic [3:0]  doB, m_data;
    logic [3:0]  ram [1024];

    int checks = 0;
    int errors = 0;

    int q_data[$], q_last[$], q_cyc[$], q_addr[$];
    int ena_cnt, done_cyc, max_out, addr1, addr_done;
    logic busy1, ena1, busy_done;

    ram_stream_reader dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
        .busy(busy), .done(done), .enaB(enaB), .addrB(addrB), .doB(doB),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (enaB) doB <= ram[addrB];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Runs one command starting in cycle 0 and records every beat, issue and
    // the done cycle. inject pulses a conflicting start in cycle 2.
    task automatic run_cmd(input int b, input int l, input bit rnd, input bit inject);
        int c, outstanding;
        logic prev_stall;
        logic [3:0] pd;
        logic pl;
        q_data.delete(); q_last.delete(); q_cyc.delete(); q_addr.delete();
        ena_cnt = 0; done_cyc = -1; max_out = 0; outstanding = 0;
        prev_stall = 1'b0; pd = '0; pl = 1'b0;
        base = 10'(b); len = 11'(l); start = 1'b1; m_ready = 1'b1;
        step;
        c = 1;
        while (c < 3000) begin
            if (inject && c == 2) begin
                start = 1'b1; base = 10'd100; len = 11'd2;
            end else start = 1'b0;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (c == 1) begin busy1 = busy; ena1 = enaB; addr1 = int'(addrB); end
            if (prev_stall) begin
                checks++;
                if (!m_valid || m_data !== pd || m_last !== pl) begin
                    errors++;
                    $display("FAIL stall_stable cycle %0d: valid=%b data=%0d last=%b, want valid=1 data=%0d last=%b",
                             c, m_valid, m_data, m_last, pd, pl);
                end
            end
            if (enaB) begin ena_cnt++; q_addr.push_back(int'(addrB)); outstanding++; end
            if (outstanding > max_out) max_out = outstanding;
            if (m_valid && m_ready) begin
                q_data.push_back(int'(m_data)); q_last.push_back(int'(m_last));
                q_cyc.push_back(c); outstanding--;
            end
            prev_stall = m_valid && !m_ready; pd = m_data; pl = m_last;
            if (done) begin
                done_cyc = c; busy_done = busy; addr_done = int'(addrB);
                break;
            end
            step;
            c++;
        end
        start = 1'b0; m_ready = 1'b1;
        step;
        if (done_cyc < 0) begin
            checks++; errors++;
            $display("FAIL timeout: no done within %0d cycles", c);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; base = '0; len = '0; m_ready = 1'b1;
        step; step;
        checks++;
        if ({busy, done, enaB, addrB, m_valid, m_last, m_data} !== '0) begin
            errors++;
            $display("FAIL reset_vals: busy=%b done=%b ena=%b addr=%0d valid=%b last=%b data=%0d, want all 0",
                     busy, done, enaB, addrB, m_valid, m_last, m_data);
        end
        rst = 1'b0;
        step;
    endtask

    task automatic test_basic;
        run_cmd(0, 8, 1'b0, 1'b0);
        checks++;
        if (busy1 !== 1'b1 || ena1 !== 1'b1 || addr1 != 0) begin
            errors++;
            $display("FAIL basic_cycle1: busy=%b ena=%b addr=%0d, want 1 1 0", busy1, ena1, addr1);
        end
        checks++;
        if (q_data.size() != 8) begin
            errors++;
            $display("FAIL basic_count: %0d beats, want 8", q_data.size());
        end else for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_data[i] != i || q_last[i] != int'(i == 7) || q_cyc[i] != 3 + i) begin
                errors++;
                $display("FAIL basic_beat%0d: data=%0d last=%0d cyc=%0d, want %0d %0d %0d",
                         i, q_data[i], q_last[i], q_cyc[i], i, int'(i == 7), 3 + i);
            end
        end
        checks++;
        if (done_cyc != 11 || busy_done !== 1'b0 || ena_cnt != 8) begin
            errors++;
            $display("FAIL basic_done: cyc=%0d busy=%b ena=%0d, want 11 0 8", done_cyc, busy_done, ena_cnt);
        end
    endtask

    task automatic test_back_pressure;
        run_cmd(0, 8, 1'b1, 1'b0);
        checks++;
        if (q_data.size() != 8) begin
            errors++;
            $display("FAIL bp_count: %0d beats, want 8", q_data.size());
        end else for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_data[i] != i || q_last[i] != int'(i == 7)) begin
                errors++;
                $display("FAIL bp_beat%0d: data=%0d last=%0d, want %0d %0d",
                         i, q_data[i], q_last[i], i, int'(i == 7));
            end
        end
        checks++;
        if (ena_cnt != 8 || max_out > 4) begin
            errors++;
            $display("FAIL bp_credit: ena=%0d max_outstanding=%0d, want 8 and <=4", ena_cnt, max_out);
        end
    endtask

    task automatic test_wrap;
        int ea[4] = '{1022, 1023, 0, 1};
        int ed[4] = '{14, 15, 0, 1};
        run_cmd(1022, 4, 1'b0, 1'b0);
        checks++;
        if (q_addr.size() != 4 || q_data.size() != 4) begin
            errors++;
            $display("FAIL wrap_count: addrs=%0d beats=%0d, want 4 4", q_addr.size(), q_data.size());
        end else for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_addr[i] != ea[i] || q_data[i] != ed[i] || q_last[i] != int'(i == 3)) begin
                errors++;
                $display("FAIL wrap_beat%0d: addr=%0d data=%0d last=%0d, want %0d %0d %0d",
                         i, q_addr[i], q_data[i], q_last[i], ea[i], ed[i], int'(i == 3));
            end
        end
        checks++;
        if (done_cyc != 7) begin
            errors++;
            $display("FAIL wrap_done: cyc=%0d, want 7", done_cyc);
        end
    endtask

    task automatic test_zero_full;
        int bad;
        run_cmd(0, 0, 1'b0, 1'b0);
        checks++;
        if (done_cyc != 1 || q_data.size() != 0 || ena_cnt != 0 || ena1 !== 1'b0) begin
            errors++;
            $display("FAIL len0: done_cyc=%0d beats=%0d ena=%0d, want 1 0 0", done_cyc, q_data.size(), ena_cnt);
        end
        run_cmd(5, 1024, 1'b0, 1'b0);
        checks++;
        if (q_data.size() != 1024 || ena_cnt != 1024) begin
            errors++;
            $display("FAIL full_count: beats=%0d ena=%0d, want 1024 1024", q_data.size(), ena_cnt);
        end else begin
            bad = -1;
            for (int i = 0; i < 1024; i++)
                if (bad < 0 && (q_data[i] != (5 + i) % 16 || q_addr[i] != (5 + i) % 1024
                                || q_last[i] != int'(i == 1023))) bad = i;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL full_beat%0d: addr=%0d data=%0d last=%0d, want %0d %0d %0d", bad,
                         q_addr[bad], q_data[bad], q_last[bad], (5 + bad) % 1024, (5 + bad) % 16,
                         int'(bad == 1023));
            end
        end
        checks++;
        if (done_cyc != 1027 || addr_done != 5) begin
            errors++;
            $display("FAIL full_done: cyc=%0d addr=%0d, want 1027 5", done_cyc, addr_done);
        end
    endtask

    task automatic test_ignored_start;
        run_cmd(0, 8, 1'b0, 1'b1);
        checks++;
        if (q_data.size() != 8 || q_addr.size() != 8) begin
            errors++;
            $display("FAIL ign_count: beats=%0d addrs=%0d, want 8 8", q_data.size(), q_addr.size());
        end else for (int i = 0; i < 8; i++) begin
            checks++;
            if (q_data[i] != i || q_addr[i] != i || q_last[i] != int'(i == 7)) begin
                errors++;
                $display("FAIL ign_beat%0d: addr=%0d data=%0d last=%0d, want %0d %0d %0d",
                         i, q_addr[i], q_data[i], q_last[i], i, i, int'(i == 7));
            end
        end
        checks++;
        if (done_cyc != 11) begin
            errors++;
            $display("FAIL ign_done: cyc=%0d, want 11", done_cyc);
        end
    endtask

    task automatic test_reset_mid;
        int stale;
        base = 10'd0; len = 11'd8; start = 1'b1; m_ready = 1'b1;
        step;
        start = 1'b0;
        for (int c = 1; c < 6; c++) step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || enaB !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: valid=%b busy=%b done=%b ena=%b, want 0 0 0 0", m_valid, busy, done, enaB);
        end
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            if (m_valid || enaB || done) stale++;
            step;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL rst_stale: %0d cycles with activity after reset, want 0", stale);
        end
        run_cmd(10, 2, 1'b0, 1'b0);
        checks++;
        if (q_data.size() != 2 || q_data[0] != 10 || q_data[1] != 11 || q_last[1] != 1) begin
            errors++;
            $display("FAIL rst_recover: beats=%0d first=%0d, want 2 beats 10,11",
                     q_data.size(), q_data.size() > 0 ? q_data[0] : -1);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 4'(i % 16);
        doB = '0;
        test_reset;
        test_basic;
        test_back_pressure;
        test_wrap;
        test_zero_full;
        test_ignored_start;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read sequencer that sits directly downstream of the wide-write / narrow-read asymmetric RAM. On a start command it walks the RAM's narrow read port over a contiguous, wrapping address range, absorbing the RAM's one-cycle registered read latency. It emits the words as a valid/ready stream with a last flag. A small credit-controlled output FIFO lets a back-pressured consumer stall the stream with no loss or duplication of data.

## Interface
Parameters:
- WIDTHB, 4: narrow read width in bits; must equal the RAM's read width.
- SIZE, 4096: RAM size in bits; must equal the RAM's SIZE.
- ADDRWIDTHB, $clog2(SIZE/WIDTHB): derived; read address width.
- LENWIDTH, ADDRWIDTHB+1: derived; length field width, so a full-RAM read is expressible.

Ports:
- clk  in  1  sole clock; rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- base  in  ADDRWIDTHB  first narrow-word address; sampled with start.
- len  in  LENWIDTH  number of narrow words to read, 0..SIZE/WIDTHB; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the command is complete.
- enaB  out  1  RAM read enable.
- addrB  out  ADDRWIDTHB  RAM read address.
- doB  in  WIDTHB  RAM read data; valid one cycle after the enaB=1 cycle.
- m_data  out  WIDTHB  stream data.
- m_valid  out  1  stream valid.
- m_last  out  1  marks the final word of the command; qualified by m_valid.
- m_ready  in  1  stream ready.

## Operation
- FSM states:
  - IDLE: busy=0. start=1 latches base, latches len into the remaining-issue counter, and moves to RUN. If len=0, move to DONE instead.
  - RUN: issue reads. Move to DRAIN when the issue counter reaches 0.
  - DRAIN: wait until the FIFO is empty and no read is in flight, then go to DONE.
  - DONE: assert done for one cycle, then return to IDLE.
- Issue rule: enaB=1 in a RUN cycle only if issues remain and credit < 4, where credit = FIFO occupancy + reads in flight.
  - Each issue post-increments addrB.
  - addrB wraps from SIZE/WIDTHB-1 to 0.
- Capture: the cycle after each issue, doB is pushed into a 4-entry FIFO. The push also carries a last bit, set when that word is the command's final word.
- Output:
  - m_data, m_valid and m_last come from the FIFO head.
  - A pop happens when m_valid and m_ready are both 1.
  - Push and pop in the same cycle leave the occupancy unchanged.
- The credit limit guarantees a push never meets a full FIFO; overflow is impossible by construction.
- The output obeys stream rules:
  - m_valid does not depend on m_ready.
  - Once m_valid is 1, m_data and m_last stay stable until the handshake.
- start while not in IDLE is ignored.
- A synchronous reset at any point, including mid-command:
  - returns the FSM to IDLE;
  - flushes the FIFO;
  - drops in-flight reads; a doB arriving the cycle after reset is discarded.

## Timing
- Reset values: busy=0, done=0, enaB=0, addrB=0, m_valid=0, m_last=0, m_data=0.
- Start latency, with start=1 in cycle 0:
  - busy=1 from cycle 1.
  - First enaB=1 with addrB=base in cycle 1.
  - doB valid in cycle 2, pushed at the end of cycle 2.
  - First m_valid=1 in cycle 3.
- Throughput: with m_ready held at 1, one word per cycle is sustained (credit depth 4 covers the 3-cycle issue-to-pop loop).
- done timing:
  - done=1 in the cycle after the handshake of the m_last word; busy falls in that same cycle.
  - For len=0: done=1 in cycle 1, with no enaB and no m_valid.
- Back-pressure: after m_ready falls, at most the in-flight reads land. enaB then stays 0 until a pop frees a credit.
- Wrap-around: base=SIZE/WIDTHB-2 with len=4 reads addresses SIZE/WIDTHB-2, SIZE/WIDTHB-1, 0, 1.

## Test plan
- Basic read:
  - Preload the RAM with word i = i mod 16 (WIDTHB=4).
  - Command start, base=0, len=8, m_ready=1.
  - Required: m_data 0..7 on cycles 3..10, m_last only on the word 7, done on cycle 11.
- Back-pressure:
  - Same command, m_ready toggled with a pseudo-random 50% pattern.
  - Required: exactly 8 words, in order, with no duplicates; FIFO occupancy never exceeds 4; the enaB count is exactly 8.
- Wrap-around:
  - base=1022, len=4 (SIZE=4096).
  - Required: addrB sequence 1022, 1023, 0, 1; data matches those locations.
- Zero and full length:
  - len=0: done on cycle 1, no stream beats.
  - len=1024: 1024 beats, last on beat 1024, addrB ending back at base.
- Reset and ignored start:
  - Assert rst after 3 beats of a len=8 command.
  - Required: the next cycle shows m_valid=0, busy=0, done=0, and no stale word appears later.
  - A start pulsed while busy is ignored: neither base nor len changes.
